// File: rtl/uk101_uart_pkg.sv
// Shared definitions for the UK101 text-feed path: sequencer states, ASCII
// constants and the byte translation applied on the way into the RX register.
// Optional build macro: ASCII_FEED_UPCASE_EN folds lowercase letters to uppercase.
package uk101_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      FETCH,
      LATCH,
      PRESENT,
      GAP,
      DONE
   } feed_state_t;

   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam int         RX_RDY_BIT = 7;

   // BASIC expects CR as the line terminator, and the stock ROMs only parse uppercase
   function automatic logic [7:0] feed_translate(input logic [7:0] raw);
      logic [7:0] result;
      result = raw;
      if (raw == ASCII_LF) begin
         result = ASCII_CR;
      end
`ifdef ASCII_FEED_UPCASE_EN
      else if ((raw >= 8'h61) && (raw <= 8'h7A)) begin
         result = raw - 8'h20;
      end
`else
      else begin
         result = raw;
      end
`endif
      return result;
   endfunction

endpackage

// File: rtl/ascii_gap_timer.sv
// Loadable down-counter that paces character delivery; it parks at zero and
// raises its zero flag until the next load.
module ascii_gap_timer #(
   parameter int WIDTH = 19
) (
   input  logic             clk25,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/ascii_feed_ctrl.sv
// Replays a downloaded text buffer into the UK101 ACIA-style RX data/status pair,
// pacing characters so BASIC keeps up. Optional macro: ASCII_FEED_UPCASE_EN.
module ascii_feed_ctrl
   import uk101_uart_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int CHAR_GAP = 4000,
   parameter int CR_GAP   = 400000
) (
   input  logic              clk25,
   input  logic              rst_n,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   output logic [ADDR_W-1:0] buf_addr,
   input  logic [7:0]        buf_data,
   input  logic              cs,
   input  logic              address,
   output logic [7:0]        dout,
   output logic              feeding
);

   localparam int GAP_MAX = (CR_GAP > CHAR_GAP) ? CR_GAP : CHAR_GAP;
   localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);

   feed_state_t       state;
   feed_state_t       state_next;
   logic              dl_active_q;
   logic              dl_rise;
   logic [ADDR_W-1:0] last_addr;
   logic              have_data;
   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic [7:0]        rx_status;
   logic              cpu_data_rd;
   logic              consume;
   logic              gap_load;
   logic [GAP_W-1:0]  gap_value;
   logic              gap_zero;

   assign dl_rise     = dl_active & ~dl_active_q;
   assign cpu_data_rd = cs & ~address;
   assign consume     = (state == PRESENT) & cpu_data_rd & ~dl_rise;

   // An abort reloads the timer with zero so a cancelled gap cannot linger
   assign gap_load  = consume | dl_rise;
   assign gap_value = dl_rise ? '0 :
                      (rx_data == ASCII_CR) ? GAP_W'(CR_GAP) : GAP_W'(CHAR_GAP);

   ascii_gap_timer #(
      .WIDTH(GAP_W)
   ) u_gap_timer (
      .clk25     (clk25),
      .rst_n     (rst_n),
      .load      (gap_load),
      .load_value(gap_value),
      .zero      (gap_zero)
   );

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A new download overrides everything; otherwise walk the fetch/present/gap loop
   always_comb begin
      state_next = state;
      if (dl_rise) begin
         state_next = ARMED;
      end else begin
         case (state)
            IDLE: begin
               state_next = IDLE;
            end
            ARMED: begin
               if (!dl_active) begin
                  state_next = have_data ? FETCH : IDLE;
               end
            end
            FETCH: begin
               state_next = LATCH;
            end
            LATCH: begin
               state_next = PRESENT;
            end
            PRESENT: begin
               if (cpu_data_rd) begin
                  state_next = GAP;
               end
            end
            GAP: begin
               if (gap_zero) begin
                  state_next = (buf_addr == last_addr) ? DONE : FETCH;
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Download extent capture; a write in the rising-edge cycle still counts
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         dl_active_q <= 1'b0;
         last_addr   <= '0;
         have_data   <= 1'b0;
      end else begin
         dl_active_q <= dl_active;
         if (dl_rise) begin
            have_data <= 1'b0;
         end
         if (dl_active && dl_wr) begin
            last_addr <= dl_addr;
            have_data <= 1'b1;
         end
      end
   end

   // End-of-buffer compare happens before the increment, so the top address never wraps
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         buf_addr <= '0;
      end else if ((state == ARMED) && (state_next == FETCH)) begin
         buf_addr <= '0;
      end else if ((state == GAP) && (state_next == FETCH)) begin
         buf_addr <= buf_addr + 1'b1;
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         rx_rdy  <= 1'b0;
         rx_data <= 8'h00;
      end else if (dl_rise) begin
         rx_rdy <= 1'b0;
      end else if (state == LATCH) begin
         rx_rdy  <= 1'b1;
         rx_data <= feed_translate(buf_data);
      end else if (consume) begin
         rx_rdy <= 1'b0;
      end
   end

   always_comb begin
      rx_status             = 8'h00;
      rx_status[RX_RDY_BIT] = rx_rdy;
   end

   // CPU read port; dout holds the last value read between accesses
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         dout <= 8'h00;
      end else if (cs) begin
         dout <= address ? rx_status : rx_data;
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         feeding <= 1'b0;
      end else begin
         feeding <= (state_next inside {FETCH, LATCH, PRESENT, GAP});
      end
   end

endmodule

// File: tb/tb_ascii_feed_ctrl.sv
// Self-checking bench for ascii_feed_ctrl: directed and randomized text feeds
// compared against a character/timing reference model held in the bench.
module tb_ascii_feed_ctrl;

   localparam int ADDR_W   = 4;
   localparam int DEPTH    = 1 << ADDR_W;
   localparam int CHAR_GAP = 4;
   localparam int CR_GAP   = 20;
   localparam int BOUND    = 100;

   // Status polls until ready: ARMED sees the fall, FETCH, LATCH, then the registered read
   localparam int FIRST_POLLS = 4;

   logic              clk25 = 1'b0;
   logic              rst_n = 1'b0;
   logic              dl_active = 1'b0;
   logic              dl_wr = 1'b0;
   logic [ADDR_W-1:0] dl_addr = '0;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_data;
   logic              cs = 1'b0;
   logic              address = 1'b0;
   logic [7:0]        dout;
   logic              feeding;

   logic [7:0] mem [DEPTH];
   int checks = 0;
   int errors = 0;

   ascii_feed_ctrl #(
      .ADDR_W  (ADDR_W),
      .CHAR_GAP(CHAR_GAP),
      .CR_GAP  (CR_GAP)
   ) dut (
      .clk25    (clk25),
      .rst_n    (rst_n),
      .dl_active(dl_active),
      .dl_wr    (dl_wr),
      .dl_addr  (dl_addr),
      .buf_addr (buf_addr),
      .buf_data (buf_data),
      .cs       (cs),
      .address  (address),
      .dout     (dout),
      .feeding  (feeding)
   );

   always #5 clk25 = ~clk25;

   // Text RAM with one cycle of read latency
   always @(posedge clk25) buf_data <= mem[buf_addr];

   function automatic logic [7:0] expect_char(input logic [7:0] b);
      if (b == 8'h0A) return 8'h0D;
`ifdef ASCII_FEED_UPCASE_EN
      if ((b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
`endif
      return b;
   endfunction

   // Gap loads N and counts N..0 (N+1 cycles), then FETCH, LATCH, registered read
   function automatic int next_polls(input logic [7:0] delivered);
      int gap;
      gap = (delivered == 8'h0D) ? CR_GAP : CHAR_GAP;
      return gap + 4;
   endfunction

   function automatic int feeding_low_polls(input logic [7:0] delivered);
      int gap;
      gap = (delivered == 8'h0D) ? CR_GAP : CHAR_GAP;
      return gap + 1;
   endfunction

   task automatic tick();
      @(posedge clk25);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic read_reg(input logic a, output logic [7:0] d);
      cs      = 1'b1;
      address = a;
      tick();
      cs = 1'b0;
      d  = dout;
   endtask

   task automatic apply_download(input logic [7:0] bytes_q[$]);
      dl_active = 1'b1;
      tick();
      foreach (bytes_q[i]) begin
         mem[i]  = bytes_q[i];
         dl_addr = ADDR_W'(i);
         dl_wr   = 1'b1;
         tick();
         dl_wr = 1'b0;
         tick();
      end
   endtask

   // Releases the download and consumes every byte, checking values, pacing and the end
   task automatic apply_stimulus(input logic [7:0] bytes_q[$], input bit inject_wr);
      logic [7:0] d;
      logic [7:0] exp_c;
      int polls;
      int want_polls;
      want_polls = FIRST_POLLS;
      exp_c      = 8'h00;
      dl_active  = 1'b0;
      foreach (bytes_q[i]) begin
         exp_c = expect_char(bytes_q[i]);
         polls = 0;
         d     = 8'h00;
         while ((d !== 8'h80) && (polls < BOUND)) begin
            if (inject_wr) begin
               dl_wr   = 1'b1;
               dl_addr = ADDR_W'(DEPTH - 1);
            end
            read_reg(1'b1, d);
            dl_wr = 1'b0;
            polls++;
         end
         check_output("rdy_latency", polls, want_polls);
         check_output("feeding_high", feeding, 1'b1);
         read_reg(1'b1, d);
         check_output("status_kept", d, 8'h80);
         read_reg(1'b0, d);
         check_output("rx_data", d, exp_c);
         want_polls = next_polls(exp_c);
      end
      polls = 0;
      do begin
         tick();
         polls++;
      end while ((feeding !== 1'b0) && (polls < BOUND));
      check_output("feeding_low", polls, feeding_low_polls(exp_c));
      check_output("end_addr", buf_addr, bytes_q.size() - 1);
      read_reg(1'b1, d);
      check_output("status_done", d, 8'h00);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] d;
      logic [7:0] any_status;
      logic       any_feeding;
      int polls;
      int len;
      int r;

      $display("[TB] ascii_feed_ctrl bench start");
      #12;
      check_output("rst_dout", dout, 8'h00);
      check_output("rst_buf_addr", buf_addr, 0);
      check_output("rst_feeding", feeding, 1'b0);
      rst_n = 1'b1;
      tick();

      // Empty download: no writes, so nothing must ever be presented
      dl_active = 1'b1;
      tick();
      tick();
      tick();
      dl_active   = 1'b0;
      any_status  = 8'h00;
      any_feeding = 1'b0;
      for (int i = 0; i < 10; i++) begin
         read_reg(1'b1, d);
         any_status  = any_status | d;
         any_feeding = any_feeding | feeding;
      end
      check_output("empty_status", any_status, 8'h00);
      check_output("empty_feeding", any_feeding, 1'b0);
      check_output("empty_buf_addr", buf_addr, 0);

      q = '{8'h41};
      apply_download(q);
      apply_stimulus(q, 1'b1);

      q = '{8'h41, 8'h0A, 8'h42};
      apply_download(q);
      apply_stimulus(q, 1'b0);

      q = '{8'h61};
      apply_download(q);
      apply_stimulus(q, 1'b0);

      // Back-to-back data reads: a read in the LATCH cycle returns the old byte
      q = '{8'h50, 8'h51};
      apply_download(q);
      dl_active = 1'b0;
      polls = 0;
      d     = 8'h00;
      while ((d !== 8'h80) && (polls < BOUND)) begin
         read_reg(1'b1, d);
         polls++;
      end
      check_output("pq_first_latency", polls, FIRST_POLLS);
      read_reg(1'b0, d);
      check_output("pq_first", d, 8'h50);
      polls = 0;
      while ((d === 8'h50) && (polls < BOUND)) begin
         read_reg(1'b0, d);
         polls++;
      end
      check_output("pq_stale_reads", polls, CHAR_GAP + 4);
      check_output("pq_second", d, 8'h51);
      read_reg(1'b1, d);
      check_output("pq_consumed", d, 8'h00);
      polls = 0;
      while ((feeding !== 1'b0) && (polls < BOUND)) begin
         tick();
         polls++;
      end
      check_output("pq_end_addr", buf_addr, 1);

      // Abort while the second of five bytes is pending, coinciding with a data read
      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      apply_download(q);
      dl_active = 1'b0;
      polls = 0;
      d     = 8'h00;
      while ((d !== 8'h80) && (polls < BOUND)) begin
         read_reg(1'b1, d);
         polls++;
      end
      read_reg(1'b0, d);
      check_output("abort_first", d, 8'h31);
      polls = 0;
      d     = 8'h00;
      while ((d !== 8'h80) && (polls < BOUND)) begin
         read_reg(1'b1, d);
         polls++;
      end
      check_output("abort_second_latency", polls, next_polls(8'h31));
      dl_active = 1'b1;
      read_reg(1'b0, d);
      check_output("abort_feeding", feeding, 1'b0);
      read_reg(1'b1, d);
      check_output("abort_status", d, 8'h00);
      q = '{8'h78, 8'h79};
      apply_download(q);
      apply_stimulus(q, 1'b1);

      // Randomized feeds mixing LF, lowercase and printable characters
      for (int it = 0; it < 5; it++) begin
         len = $urandom_range(1, 6);
         q.delete();
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) q.push_back(8'h0A);
            else if (r < 4) q.push_back(8'($urandom_range(8'h61, 8'h7A)));
            else q.push_back(8'($urandom_range(8'h20, 8'h5F)));
         end
         apply_download(q);
         apply_stimulus(q, 1'($urandom_range(0, 1)));
      end

      // Full buffer: last address is all ones and must not wrap
      q.delete();
      for (int k = 0; k < DEPTH; k++) q.push_back(8'($urandom_range(8'h20, 8'h7A)));
      apply_download(q);
      apply_stimulus(q, 1'b0);
      for (int i = 0; i < 6; i++) tick();
      check_output("nowrap_addr", buf_addr, DEPTH - 1);
      check_output("nowrap_feeding", feeding, 1'b0);

      // Asynchronous reset in the middle of the second gap
      q = '{8'h41, 8'h42};
      apply_download(q);
      dl_active = 1'b0;
      for (int b = 0; b < 2; b++) begin
         polls = 0;
         d     = 8'h00;
         while ((d !== 8'h80) && (polls < BOUND)) begin
            read_reg(1'b1, d);
            polls++;
         end
         read_reg(1'b0, d);
      end
      check_output("pre_rst_dout", d, 8'h42);
      check_output("pre_rst_addr", buf_addr, 1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_dout", dout, 8'h00);
      check_output("mid_rst_addr", buf_addr, 0);
      check_output("mid_rst_feeding", feeding, 1'b0);
      #3;
      rst_n = 1'b1;
      tick();
      read_reg(1'b1, d);
      check_output("post_rst_status", d, 8'h00);
      for (int i = 0; i < 30; i++) tick();
      check_output("post_rst_feeding", feeding, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ascii_feed_ctrl.md
Name: ascii_feed_ctrl

Overview:
- Sequencer that replays a text file, loaded over the ioctl download path, into the UK101 serial RX register as if it were typed.
- Records the extent of the download and fetches bytes from an external text buffer RAM with 1-cycle read latency.
- Presents each byte to the CPU through an ACIA-style RX data/status pair and paces delivery, with a longer gap after line ends so BASIC can tokenise.
- Sits between the ioctl loader/text RAM and the CPU address decoder.

Parameters:
- ADDR_W, 16, text buffer address width.
- CHAR_GAP, 4000, clk25 cycles of idle time after each consumed character.
- CR_GAP, 400000, clk25 cycles of idle time after a delivered CR (0x0D).

Ports:
- clk25  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous active-low reset.
- dl_active  in  1  ioctl download in progress.
- dl_wr  in  1  one-cycle strobe; a byte is written to the text RAM at dl_addr.
- dl_addr  in  ADDR_W  address of the byte being written.
- buf_addr  out  ADDR_W  text RAM read address.
- buf_data  in  8  text RAM read data, valid 1 cycle after buf_addr.
- cs  in  1  CPU chip select, active high, one cycle per access.
- address  in  1  0 = RX data, 1 = RX status.
- dout  out  8  CPU read data, registered.
- feeding  out  1  high from the first fetch until the last byte is consumed.

Behaviour:
- Reset: state IDLE; dout=0; buf_addr=0; feeding=0; rx_rdy=0; rx_data=0; last_addr=0; have_data=0; gap counter=0.
- Capture:
  - While dl_active, each dl_wr sets last_addr=dl_addr and have_data=1.
  - Rising edge of dl_active clears have_data, cancels any feed in progress, clears rx_rdy and enters ARMED from any state.
- ARMED: on dl_active low, go to FETCH with buf_addr=0 if have_data=1, otherwise go to IDLE.
- FETCH: drive buf_addr for one cycle, then go to LATCH.
- LATCH:
  - rx_data = buf_data, with 0x0A translated to 0x0D.
  - Set rx_rdy=1 and go to PRESENT.
  - feeding=1 from the first FETCH onward.
- PRESENT: hold until a CPU data read (cs=1, address=0).
  - That read clears rx_rdy next edge.
  - Load the gap counter with CR_GAP if rx_data==0x0D, else CHAR_GAP.
  - Go to GAP.
- GAP: count down to 0.
  - At 0, if buf_addr==last_addr, go to DONE.
  - Otherwise increment buf_addr and go to FETCH.
  - Compare before increment, so last_addr=0xFFFF never wraps.
- DONE: feeding=0, go to IDLE.
- Byte latency: first byte presented 2 cycles after dl_active falls (FETCH, LATCH).
- CPU reads, registered (dout updates the edge after cs):
  - address=0 returns rx_data.
  - address=1 returns {rx_rdy, 7'b0}.
  - A status read never clears rx_rdy.
  - A data read while rx_rdy=0 returns stale rx_data with no state change.
- Simultaneous events:
  - Data read in the same cycle LATCH sets rx_rdy: the set wins, and the read returns the previous rx_data.
  - Download rising edge coinciding with a CPU read: the abort wins.
- dl_wr while dl_active=0 is ignored.
- Mid-operation reset returns all state to reset values immediately.

Optional Feature:
- Macro ASCII_FEED_UPCASE_EN.
- Defined: LATCH also maps 0x61-0x7A to 0x41-0x5A, for the uppercase-only UK101 monitor/BASIC.
- Undefined: bytes pass unchanged except the LF to CR translation.

Decomposition:
- Shared package uk101_uart_pkg holds:
  - state enum (IDLE, ARMED, FETCH, LATCH, PRESENT, GAP, DONE);
  - constants ASCII_LF=8'h0A and ASCII_CR=8'h0D;
  - RX status bit position (7).
- One natural sub-module: ascii_gap_timer, a loadable down-counter with load value, load strobe and zero flag, sized to hold CR_GAP.

Test Plan:
- Bench: CHAR_GAP=4, CR_GAP=20.
- Single-byte feed: dl_wr addr0=0x41 then dl_active low -> status read 0x80; data read 0x41; status 0x00; feeding low after 4-cycle gap.
- LF translation and pacing: RAM "A\nB" -> CPU sees 0x41, 0x0D, 0x42; gap after 0x0D is 20 cycles, else 4; next rx_rdy 2 cycles after gap end.
- Abort: dl_active re-asserted while second of 5 bytes pending -> rx_rdy=0, feeding=0; new 2-byte download replays from addr 0 only.
- Empty download: dl_active pulse with no dl_wr -> returns IDLE, rx_rdy never set, buf_addr stays 0.
- Boundary: last_addr=0xFFFF with buf_addr preset near end -> stops after 0xFFFF, no wrap to 0; status reads never clear rx_rdy.
- ASCII_FEED_UPCASE_EN: 0x61 -> 0x41 when defined; 0x61 -> 0x61 when undefined; async rst_n low mid-GAP -> all outputs 0 same cycle.
